// File: rtl/dilithium_stream_framer.sv
//------------------------------------------------------------------------------
// Module   : dilithium_stream_framer
// Brief    : Frames a core word stream into len_i-word frames through a small
//            output FIFO; FRAMER_OVERRUN_CHECK_EN enables overrun drop + err.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dilithium_stream_framer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   mem [DEPTH];

  logic              start_edge;
  logic              full;
  logic              empty;
  logic              in_acc;
  logic              push;
  logic              pop;
  logic              in_last;
  logic [DATA_W:0]   head;

  always_comb begin
    start_edge = start & ~start_q;
    empty      = (wptr_q == rptr_q);
    full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    head       = mem[rptr_q[AW-1:0]];

    // in_ready depends only on state and pointers, never on out_ready
    in_ready = 1'b0;
    if (state_q == S_STREAM) begin
      in_ready = ~full;
    end else begin
`ifdef FRAMER_OVERRUN_CHECK_EN
      in_ready = 1'b1;
`else
      in_ready = 1'b0;
`endif
    end
    in_ready = in_ready & rst;

    in_acc    = in_valid & in_ready;
    push      = in_acc & (state_q == S_STREAM);
    out_valid = ~empty;
    out_data  = empty ? '0 : head[DATA_W-1:0];
    out_last  = ~empty & head[DATA_W];
    pop       = out_valid & out_ready;
    in_last   = ((cnt_q + LEN_W'(1)) == len_q);
    busy      = (state_q != S_IDLE);
    done      = done_q;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    done_d  = 1'b0;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          len_d = len_i;
          cnt_d = '0;
          if (len_i == '0) done_d = 1'b1;
          else             state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (push) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (in_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // start_q resets high so a start level held across reset release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= {in_last, in_data};
  end

`ifdef FRAMER_OVERRUN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == S_IDLE) && start_edge) err_d = 1'b0;
    if (in_acc && (state_q != S_STREAM))   err_d = 1'b1;
    err = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dilithium_stream_framer.sv
//------------------------------------------------------------------------------
// Module   : tb_dilithium_stream_framer
// Brief    : Scoreboard bench for dilithium_stream_framer (default parameters).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dilithium_stream_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] len_i = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int pop_cyc[$];
  logic [64:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [64:0] hold_val = '0;

  dilithium_stream_framer #(.DATA_W(64), .DEPTH(4), .LEN_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .len_i(len_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    logic [64:0] e;
    cyc++;
    if (!rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_pend) begin
        checks++;
        if (!out_valid || {out_last, out_data} !== hold_val) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b %h required %h", out_valid, {out_last, out_data}, hold_val);
        end
      end
      hold_pend <= out_valid & ~out_ready;
      hold_val  <= {out_last, out_data};
      if (out_valid && out_ready) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h required none", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL out_word: got last=%0b data=%h required last=%0b data=%h",
                     out_last, out_data, e[64], e[63:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [11:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    len_i = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [63:0] base, input int len_tag);
    for (int i = 0; i < n; i++) begin
      int t;
      in_data  = base + 64'(i);
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
      exp_q.push_back({(i + 1 == len_tag) ? 1'b1 : 1'b0, base + 64'(i)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    @(negedge clk);
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0, p0;
    // Reset values with start already high through release
    start = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("held_start_no_frame", 64'(busy), 0);
    start = 1'b0;
    @(posedge clk); #1;

    // Basic frame of four words, free-flowing output
    out_ready = 1'b1;
    d0 = done_cnt;
    start_frame(12'd4);
    chk("busy_after_start", 64'(busy), 1);
    pop_cyc.delete();
    send_words(4, 64'hA0A0_0000_0000_0000, 4);
    wait_idle(50);
    chk("basic_pops", 64'(pop_cyc.size()), 4);
    if (pop_cyc.size() == 4) chk("basic_consecutive", 64'(pop_cyc[3] - pop_cyc[0]), 3);
    chk("basic_done", 64'(done_cnt - d0), 1);
    chk("basic_busy_low", 64'(busy), 0);
    chk("basic_sb_empty", 64'(exp_q.size()), 0);

    // Backpressure: buffer fills after DEPTH words
    out_ready = 1'b0;
    p0 = pop_cnt;
    start_frame(12'd8);
    fork
      send_words(8, 64'h1111_2222_3333_0000, 8);
      begin
        repeat (12) @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 0);
        chk("full_out_valid", 64'(out_valid), 1);
        chk("full_no_pops", 64'(pop_cnt - p0), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle(100);
    chk("bp_pops", 64'(pop_cnt - p0), 8);
    chk("bp_sb_empty", 64'(exp_q.size()), 0);

    // Start held high, second edge in DRAIN ignored
    out_ready = 1'b0;
    d0 = done_cnt;
    p0 = pop_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len_i = 12'd2;
    @(posedge clk); #1;
    send_words(2, 64'h5555_0000_0000_0010, 2);
    repeat (15) @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    len_i = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    wait_idle(50);
    repeat (5) @(negedge clk);
    chk("held_done_once", 64'(done_cnt - d0), 1);
    chk("held_pops", 64'(pop_cnt - p0), 2);
    chk("held_no_refire", 64'(busy), 0);
    chk("held_no_valid", 64'(out_valid), 0);

    // Zero-length frame
    @(posedge clk); #1;
    start = 1'b1;
    len_i = 12'd0;
    #3;
    chk("zero_done_not_yet", 64'(done), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done_pulse", 64'(done), 1);
    chk("zero_busy", 64'(busy), 0);
    chk("zero_out_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    chk("zero_done_single", 64'(done), 0);

    // Extra word beyond the frame length
    out_ready = 1'b1;
    p0 = pop_cnt;
    start_frame(12'd2);
    send_words(2, 64'h7777_0000_0000_0020, 2);
    in_data  = 64'hDEAD_BEEF_0000_0003;
    in_valid = 1'b1;
    @(negedge clk);
`ifdef FRAMER_OVERRUN_CHECK_EN
    chk("ovr_in_ready", 64'(in_ready), 1);
`else
    chk("ovr_in_ready", 64'(in_ready), 0);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle(50);
    chk("ovr_pops", 64'(pop_cnt - p0), 2);
`ifdef FRAMER_OVERRUN_CHECK_EN
    chk("ovr_err_set", 64'(err), 1);
    start_frame(12'd1);
    chk("ovr_err_cleared", 64'(err), 0);
    send_words(1, 64'h7777_0000_0000_0030, 1);
    wait_idle(50);
`else
    chk("ovr_err_zero", 64'(err), 0);
`endif

    // Reset mid-frame with two words buffered
    out_ready = 1'b0;
    start_frame(12'd6);
    send_words(3, 64'h9999_0000_0000_0040, 6);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", 64'(out_last), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 0);
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_done", 64'(done_cnt - d0), 0);
    out_ready = 1'b1;
    start_frame(12'd1);
    send_words(1, 64'hCAFE_0000_0000_0001, 1);
    wait_idle(50);
    chk("post_rst_done", 64'(done_cnt - d0), 1);
    chk("post_rst_sb_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dilithium_stream_framer.md
DILITHIUM_STREAM_FRAMER -- requirements
Module: dilithium_stream_framer

Interface
REQ-001 Parameter DATA_W, default 64: width of data words on both stream sides.
REQ-002 Parameter DEPTH, default 4: output buffer depth in words, power of two, minimum 2.
REQ-003 Parameter LEN_W, default 12: width of the frame word count.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 start  input  1: level request; only its rising edge starts a frame.
REQ-007 len_i  input  LEN_W: frame length in words, sampled on the start edge.
REQ-008 in_valid / in_ready  input / output  1: core-side handshake.
REQ-009 in_data  input  DATA_W: core output word.
REQ-010 out_valid / out_ready  output / input  1: consumer-side handshake.
REQ-011 out_data  output  DATA_W: buffered word.
REQ-012 out_last  output  1: high with the final word of a frame.
REQ-013 busy  output  1: high from the start edge until the last word is consumed.
REQ-014 done  output  1: single-cycle pulse after the last word is consumed.
REQ-015 err  output  1: sticky overrun flag, cleared only by reset or the next start edge.

Function
REQ-016 The block SHALL detect the start edge internally with a registered copy of start; a level held high SHALL start exactly one frame.
REQ-017 State machine IDLE, STREAM, DRAIN: IDLE->STREAM on a start edge with len_i!=0; STREAM->DRAIN when word len_i is accepted; DRAIN->IDLE when out_last is consumed.
REQ-018 Start edge with len_i==0: no words are framed, state stays IDLE, done pulses on the next cycle, busy stays low.
REQ-019 Start edges in STREAM or DRAIN SHALL be ignored; len_i is not resampled.
REQ-020 Input accept = in_valid & in_ready; in STREAM, in_ready = buffer not full, with no combinational path from out_ready.
REQ-021 An input counter SHALL count accepted words; the word whose count equals len_i is stored with a last tag.
REQ-022 The buffer SHALL be a DEPTH-entry circular FIFO storing DATA_W+1 bits per entry; pointers wrap modulo DEPTH with an extra wrap bit for full/empty.
REQ-023 A word accepted in cycle N SHALL appear on out_data in cycle N+1 at the earliest; out_valid = buffer not empty.
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged, including at DEPTH-1 occupancy.
REQ-025 out_data and out_last SHALL hold stable while out_valid & !out_ready.
REQ-026 done SHALL pulse in the cycle after the last-tagged word is popped; busy falls in that same cycle.
REQ-027 Words SHALL be emitted in acceptance order, unmodified.

Reset
REQ-028 Reset low SHALL immediately force: state IDLE, pointers and counter zero, in_ready 0, out_valid 0, out_last 0, out_data 0, busy 0, done 0, err 0.
REQ-029 Reset mid-frame SHALL discard all buffered words; no done pulse results.
REQ-030 After reset release, start high on the first cycle SHALL count as a rising edge only if start was low in at least one clocked cycle after release.

Configuration
REQ-031 Macro FRAMER_OVERRUN_CHECK_EN defined: in IDLE and DRAIN, in_ready=1; any accepted word is discarded and err is set.
REQ-032 Macro FRAMER_OVERRUN_CHECK_EN undefined: in_ready=0 outside STREAM; err is tied to 0.

Verification
REQ-033 Defaults; start edge, len_i=4; four words A,B,C,D; out_ready=1 -> out A..D on consecutive cycles; out_last only with D; done pulses once; busy low afterwards.
REQ-034 DEPTH=4, len_i=8, out_ready=0 -> in_ready drops after 4 accepts; raise out_ready -> remaining 4 words flow with no loss and no duplication; out_last on word 8.
REQ-035 start held high 20 cycles, len_i=2 -> exactly one frame of 2 words and one done pulse; a second start edge during DRAIN is ignored.
REQ-036 Start edge with len_i=0 -> no out_valid; done pulses 1 cycle later; busy stays 0.
REQ-037 With FRAMER_OVERRUN_CHECK_EN, len_i=2, core drives 3 words -> 2 words output; third accepted and dropped; err=1 until the next start edge. Without the macro -> third word stalled (in_ready=0); err=0.
REQ-038 Reset asserted after 3 of 6 words with 2 buffered -> outputs zero immediately; a new frame with len_i=1 afterwards completes normally.
